// File: rtl/bitstream_decimator.sv
// Bitstream decimator: counts ones over back-to-back windows of 2^LOG2_OSR
// accepted bits and hands each count downstream through a valid/ready hold register.
module bitstream_decimator #(
    parameter int unsigned LOG2_OSR = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic [LOG2_OSR:0] sample_out,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overrun,
    input  logic              clr_ovr,
    output logic              busy
);

    localparam int unsigned SW  = LOG2_OSR + 1;
    localparam int unsigned OSR = 1 << LOG2_OSR;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [LOG2_OSR-1:0] bit_cnt;
    logic [SW-1:0]       ones_cnt;
    logic                accept_c;
    logic                win_end_c;
    logic                xfer_c;
    logic [SW-1:0]       result_c;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en)  state_nxt = ACCUM;
            ACCUM:   if (!en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Acceptance and window-end decode; IDLE with en=1 accepts so entry costs no cycle
    always_comb begin
        accept_c  = 1'b0;
        win_end_c = 1'b0;
        xfer_c    = sample_valid & sample_ready;
        result_c  = ones_cnt + SW'(bit_in);
        if (state_nxt == ACCUM) begin
            accept_c = bit_valid;
        end
        win_end_c = accept_c && (bit_cnt == LOG2_OSR'(OSR - 1));
    end

    // Window counters; dropping en clears any partial window
    always_ff @(posedge clk) begin
        if (!rst || !en) begin
            bit_cnt  <= '0;
            ones_cnt <= '0;
        end else if (accept_c) begin
            bit_cnt <= bit_cnt + LOG2_OSR'(1);
            if (win_end_c) begin
                ones_cnt <= '0;
            end else begin
                ones_cnt <= result_c;
            end
        end
    end

    // Output hold register, overrun flag and busy
    always_ff @(posedge clk) begin
        if (!rst) begin
            sample_out   <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            busy <= (state_nxt == ACCUM);
            if (win_end_c && (!sample_valid || xfer_c)) begin
                sample_out   <= result_c;
                sample_valid <= 1'b1;
            end else if (xfer_c) begin
                sample_valid <= 1'b0;
            end
            // A new drop outranks a simultaneous clear
            if (win_end_c && sample_valid && !xfer_c) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bitstream_decimator.sv
// Directed bench for bitstream_decimator with OSR=8: vector table plus corner sequences.
module tb_bitstream_decimator;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       bit_in;
    logic       bit_valid;
    logic [3:0] sample_out;
    logic       sample_valid;
    logic       sample_ready;
    logic       overrun;
    logic       clr_ovr;
    logic       busy;

    int checks = 0;
    int errors = 0;

    bitstream_decimator #(.LOG2_OSR(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .clr_ovr      (clr_ovr),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic       bv;
        logic       b;
        logic       rdy;
        logic       clr;
        logic [3:0] out;
        logic       vld;
        logic       ovr;
        logic       bsy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic e, input logic bv, input logic b,
                                input logic rd, input logic c, input logic [3:0] o,
                                input logic vl, input logic ov, input logic bs);
        vec_t t;
        t.rst = r; t.en = e; t.bv = bv; t.b = b; t.rdy = rd; t.clr = c;
        t.out = o; t.vld = vl; t.ovr = ov; t.bsy = bs;
        return t;
    endfunction

    // Drive inputs mid-cycle, then sample 1 time unit after the rising edge
    task automatic cyc(input logic r, input logic e, input logic bv, input logic b,
                       input logic rd, input logic c);
        @(negedge clk);
        rst = r; en = e; bit_valid = bv; bit_in = b; sample_ready = rd; clr_ovr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] o, input logic vl,
                       input logic ov, input logic bs);
        checks++;
        if (sample_out !== o || sample_valid !== vl || overrun !== ov || busy !== bs) begin
            errors++;
            $display("FAIL %s: got out=%0d vld=%b ovr=%b busy=%b, want out=%0d vld=%b ovr=%b busy=%b",
                     name, sample_out, sample_valid, overrun, busy, o, vl, ov, bs);
        end
    endtask

    // Feed one 8-bit window (MSB first) with bit_valid held high
    task automatic window(input logic [7:0] bits, input logic rd);
        for (int i = 7; i >= 0; i--) cyc(1, 1, 1, bits[i], rd, 0);
    endtask

    initial begin
        rst = 0; en = 0; bit_valid = 0; bit_in = 0; sample_ready = 1; clr_ovr = 0;

        // Reset, then a window of eight ones with ready held high
        tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 7; i++) tbl.push_back(mk(1, 1, 1, 1, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 1, 1, 0, 8, 1, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 8, 0, 0, 1));
        // Window 11111000 held with ready low, then window 01000001 ends with a transfer
        for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 1, 1, 1, 0, 0, 8, 0, 0, 1));
        for (int i = 0; i < 2; i++) tbl.push_back(mk(1, 1, 1, 0, 0, 0, 8, 0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 5, 1, 0, 1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 5, 1, 0, 1));
        tbl.push_back(mk(1, 1, 1, 1, 0, 0, 5, 1, 0, 1));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 1, 1, 0, 0, 0, 5, 1, 0, 1));
        tbl.push_back(mk(1, 1, 1, 1, 1, 0, 2, 1, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 2, 0, 0, 1));
        // Abort after 5 bits (3 ones), then a full window of ones must give 8
        tbl.push_back(mk(1, 1, 1, 1, 1, 0, 2, 0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 1, 1, 0, 2, 0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 0, 1, 0, 2, 0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 1, 1, 0, 2, 0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 0, 1, 0, 2, 0, 0, 1));
        tbl.push_back(mk(1, 0, 1, 1, 1, 0, 2, 0, 0, 0));
        for (int i = 0; i < 7; i++) tbl.push_back(mk(1, 1, 1, 1, 1, 0, 2, 0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 1, 1, 0, 8, 1, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 8, 0, 0, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].rst, tbl[i].en, tbl[i].bv, tbl[i].b, tbl[i].rdy, tbl[i].clr);
            chk($sformatf("vec%0d", i), tbl[i].out, tbl[i].vld, tbl[i].ovr, tbl[i].bsy);
        end

        // Alternating bits 10101010 with two idle cycles after each bit
        for (int i = 0; i < 8; i++) begin
            cyc(1, 1, 1, (i % 2 == 0), 1, 0);
            if (i < 7) chk($sformatf("gap_bit%0d", i), 8, 0, 0, 1);
            else       chk("gap_result", 4, 1, 0, 1);
            cyc(1, 1, 0, 1, 1, 0);
            cyc(1, 1, 0, 1, 1, 0);
        end
        chk("gap_consumed", 4, 0, 0, 1);
        window(8'b0000_0000, 1);
        chk("zero_window", 0, 1, 0, 1);
        cyc(1, 1, 0, 0, 1, 0);
        chk("zero_consumed", 0, 0, 0, 1);

        // Overrun: two windows with ready low, clear, set-beats-clear, then drain
        window(8'b1110_0000, 0);
        chk("ovr_first", 3, 1, 0, 1);
        window(8'b1111_1000, 0);
        chk("ovr_set", 3, 1, 1, 1);
        cyc(1, 1, 0, 0, 0, 1);
        chk("ovr_clear", 3, 1, 0, 1);
        for (int i = 0; i < 7; i++) cyc(1, 1, 1, 0, 0, 0);
        cyc(1, 1, 1, 1, 0, 1);
        chk("ovr_set_wins", 3, 1, 1, 1);
        cyc(1, 1, 0, 0, 0, 1);
        chk("ovr_clear2", 3, 1, 0, 1);
        cyc(1, 1, 0, 0, 1, 0);
        chk("ovr_drain", 3, 0, 0, 1);

        // Reset mid-window with a sample pending
        window(8'b1111_1000, 0);
        chk("rst_pending", 5, 1, 0, 1);
        for (int i = 0; i < 4; i++) cyc(1, 1, 1, 1, 0, 0);
        cyc(0, 1, 1, 1, 1, 1);
        chk("rst_mid", 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 1, 1, 1, 0);
        chk("rst_no_early_end", 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(1, 1, 1, 1, 1, 0);
        chk("rst_window", 8, 1, 0, 1);
        cyc(1, 0, 0, 0, 1, 0);
        chk("idle_consumed", 8, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bitstream_decimator.md
BITSTREAM_DECIMATOR -- requirements
Module: bitstream_decimator

Interface
REQ-001 Parameter LOG2_OSR, default 6, SHALL set the decimation window OSR = 2^LOG2_OSR accepted bits (legal range 2..10).
REQ-002 Derived width SW = LOG2_OSR+1 SHALL hold counts 0..OSR inclusive.
REQ-003 clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 en  input  1  SHALL enable decimation; low SHALL abort the current window.
REQ-006 bit_in  input  1  SHALL carry the modulator bitstream (acc output y).
REQ-007 bit_valid  input  1  SHALL qualify bit_in; a bit is accepted when en=1 and bit_valid=1 on a rising edge.
REQ-008 sample_out  output  SW  SHALL carry the held count of ones in the last completed window.
REQ-009 sample_valid  output  1  SHALL indicate sample_out holds an unconsumed sample.
REQ-010 sample_ready  input  1  SHALL signal downstream consumption; a transfer occurs when sample_valid=1 and sample_ready=1.
REQ-011 overrun  output  1  SHALL be a sticky flag: a completed window was dropped.
REQ-012 clr_ovr  input  1  SHALL clear overrun.
REQ-013 busy  output  1  SHALL be 1 while state is ACCUM.

Function
REQ-014 FSM states SHALL be IDLE and ACCUM only.
REQ-015 IDLE -> ACCUM when en=1; ACCUM -> IDLE when en=0; no other transitions.
REQ-016 In IDLE, bit_cnt and ones_cnt SHALL be 0 and no bits SHALL be accepted.
REQ-017 Entering ACCUM SHALL not consume a cycle: a bit with en=1, bit_valid=1 in the IDLE->ACCUM cycle SHALL be accepted.
REQ-018 Each accepted bit SHALL increment bit_cnt (LOG2_OSR bits, wraps OSR-1 -> 0) and add bit_in to ones_cnt.
REQ-019 Cycles with bit_valid=0 SHALL leave bit_cnt and ones_cnt unchanged.
REQ-020 On the accepted bit with bit_cnt=OSR-1 (window end), result = ones_cnt + bit_in (SW bits, no saturation needed) and ones_cnt SHALL restart at 0 next cycle.
REQ-021 At window end, result SHALL load sample_out and set sample_valid on the next rising edge (latency 1 cycle after the last bit) if sample_valid=0 or a transfer occurs in the same cycle.
REQ-022 At window end with sample_valid=1 and no transfer, result SHALL be discarded, sample_out unchanged, overrun set to 1.
REQ-023 A transfer without a simultaneous load SHALL clear sample_valid next cycle; sample_out SHALL keep its value.
REQ-024 sample_out SHALL not change while sample_valid=1 except via REQ-021 load-with-transfer.
REQ-025 en=0 mid-window SHALL discard partial counts next cycle; sample_out, sample_valid, overrun SHALL be unaffected; transfers SHALL still complete.
REQ-026 clr_ovr=1 SHALL clear overrun next cycle; simultaneous set (REQ-022) SHALL win.
REQ-027 Windows SHALL be back-to-back: the bit after a window end SHALL be bit 0 of the next window.

Reset
REQ-028 rst=0 at a rising edge SHALL force state=IDLE, bit_cnt=0, ones_cnt=0, sample_out=0, sample_valid=0, overrun=0, busy=0, overriding all other inputs.
REQ-029 Reset mid-window SHALL discard the partial window; the first window after release SHALL start at bit 0.

Verification (LOG2_OSR=3, OSR=8, sample_ready=1 unless stated)
REQ-030 en=1, 8 valid bits all 1 -> sample_out=8, sample_valid=1 for exactly one cycle, 1 cycle after 8th bit.
REQ-031 8 valid bits 10101010 with bit_valid gaps of 2 cycles -> sample_out=4; all-zero window -> sample_out=0 with sample_valid=1.
REQ-032 sample_ready=0, two full windows (counts 3 then 5) -> sample_out stays 3, overrun=1; clr_ovr pulse -> overrun=0; sample_ready=1 -> transfer, sample_valid=0.
REQ-033 sample_ready=1 held, window end coincident with transfer of prior sample -> new value loaded, sample_valid stays 1, overrun=0.
REQ-034 en=0 after 5 bits (3 ones), then en=1 and 8 ones -> sample_out=8, not 11.
REQ-035 rst=0 after 4 bits of a window with a valid sample pending -> all outputs 0; next 8 ones -> sample_out=8.
